mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the data-memory bus of the 32-bit RISC computer.
- Snoops the computer's memwrite/dataadr/writedata outputs and claims stores to its own address window; dmem still sees the same stores unchanged.
- Queues store bytes in a FIFO and serialises them 8N1, LSB first, on a single tx line.
- Exposes status flags for testbench and LED observation.

---
 rtl/mmio_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter sitting beside dmem on the data bus of the
// 32-bit RISC computer. It snoops stores and claims two addresses:
//   BASE_ADDR     TXDATA  : store pushes writedata[7:0] into the TX FIFO
//   BASE_ADDR + 4 STATUS  : store clears the sticky overflow flag
// dmem still sees every store; this block only observes the bus.
// Queued bytes are sent 8N1, LSB first, on tx.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
//
// Ports:
//   clk        in   system clock, rising-edge
//   reset      in   synchronous, active-high reset
//   memwrite   in   store strobe
//   dataadr    in   store byte address (full 32-bit decode)
//   writedata  in   store data, bits [7:0] used
//   tx         out  serial line, idles high (registered)
//   tx_busy    out  high whenever the FSM is not in IDLE
//   fifo_count out  queued bytes, not counting the byte on the wire
//   overflow   out  sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memwrite,
    input  logic [31:0]                 dataadr,
    input  logic [31:0]                 writedata,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] CNT_MAX  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mmio_uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("mmio_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic w_push_req;
    logic w_clr_req;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_unused_wdata;

    assign w_push_req = memwrite && (dataadr == BASE_ADDR);
    assign w_clr_req  = memwrite && (dataadr == (BASE_ADDR + 32'd4));

    // Upper store bits are architecturally ignored.
    assign w_unused_wdata = ^writedata[31:8];

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    w_head;
    logic          w_have;
    logic          w_pop;

    // Fullness is judged on the pre-edge count, so a pop on the same edge
    // does not make room for the push.
    assign w_full = (r_count == CNT_FULL);
    assign w_push = w_push_req && !w_full;
    assign w_drop = w_push_req &&  w_full;
    assign w_head = r_mem[r_rd_ptr];
    assign w_have = (r_count != '0);

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // A drop on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_clr_req) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Serialiser FSM
    // -----------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_n;
    logic [BCW-1:0] r_bit_cnt;
    logic [BCW-1:0] w_bit_cnt_n;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_n;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_n;
    logic           r_tx;
    logic           w_tx_n;
    logic           w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic           r_parity;
`endif

    assign w_bit_done = (r_bit_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_tx      <= w_tx_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is latched at pop time because the shift register is consumed
    // while the data bits go out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_tx_n      = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_n = 1'b1;
                if (w_have) begin
                    w_pop       = 1'b1;
                    w_shift_n   = w_head;
                    w_state_n   = S_START;
                    w_bit_cnt_n = '0;
                    w_tx_n      = 1'b0;
                end
            end

            S_START: begin
                if (w_bit_done) begin
                    w_state_n   = S_DATA;
                    w_bit_cnt_n = '0;
                    w_bit_idx_n = '0;
                    w_tx_n      = r_shift[0];
                end else begin
                    w_bit_cnt_n = r_bit_cnt + BCW'(1);
                end
            end

            S_DATA: begin
                if (w_bit_done) begin
                    w_bit_cnt_n = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
                        w_tx_n    = r_parity;
`else
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
`endif
                    end else begin
                        // Shift right so the next bit is always at [1]
                        // now and at [0] after this edge.
                        w_bit_idx_n = r_bit_idx + 3'd1;
                        w_shift_n   = {1'b0, r_shift[7:1]};
                        w_tx_n      = r_shift[1];
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + BCW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_n   = S_STOP;
                    w_bit_cnt_n = '0;
                    w_tx_n      = 1'b1;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + BCW'(1);
                end
            end
`endif

            S_STOP: begin
                if (w_bit_done) begin
                    w_bit_cnt_n = '0;
                    if (w_have) begin
                        // Back-to-back frame: no idle gap.
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_state_n = S_START;
                        w_tx_n    = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                        w_tx_n    = 1'b1;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + BCW'(1);
                end
            end

            default: begin
                w_state_n   = S_IDLE;
                w_bit_cnt_n = '0;
                w_tx_n      = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign tx         = r_tx;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
